// File: rtl/reduce_pkg.sv
// ----------------------------------------------------------------------------
// reduce_pkg
//   Shared types and helpers for the pipelined reduction tree.
//   - reduce_op_t : reduction mode (OR / AND / XOR / NOR zero-flag)
//   - num_stages  : pipeline depth for a given width and levels-per-stage
//   - combine     : one 2-input tree node; NOR nodes combine as OR, the
//                   inversion is applied once at the root by the last stage
// ----------------------------------------------------------------------------
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } reduce_op_t;

  // ceil(log2(width) / lvls_per_stg)
  function automatic int num_stages(input int width, input int lvls_per_stg);
    return ($clog2(width) + lvls_per_stg - 1) / lvls_per_stg;
  endfunction

  function automatic logic combine(input logic a, input logic b, input reduce_op_t op);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = a | b;   // OP_OR and OP_NOR
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// ----------------------------------------------------------------------------
// reduce_stage
//   One pipeline stage of the reduction tree: LVLS combinational 2-input
//   levels followed by a valid/data/op register that holds under stall.
//
// Parameters
//   IN_W  : input node count (power of 2)
//   LVLS  : tree levels folded in this stage; output width is IN_W >> LVLS
//   LAST  : root stage, applies the NOR inversion before the register
//
// Ports
//   clk, rst_n   : clock, async active-low reset
//   in_vld       : upstream stage holds a valid item
//   in_data/op   : upstream nodes and mode
//   nxt_adv      : downstream stage advances (out_ready for the root stage)
//   adv          : this stage advances (empty or downstream advances)
//   out_vld/data/op : registered stage outputs
//   in_par/out_par  : parallel XOR tree, only with REDUCE_TREE_PARITY_EN
// ----------------------------------------------------------------------------
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int LVLS = 2,
  parameter bit LAST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic [IN_W-1:0]          in_data,
  input  reduce_op_t               in_op,
`ifdef REDUCE_TREE_PARITY_EN
  input  logic [IN_W-1:0]          in_par,
  output logic [(IN_W>>LVLS)-1:0]  out_par,
`endif
  input  logic                     nxt_adv,
  output logic                     adv,
  output logic                     out_vld,
  output logic [(IN_W>>LVLS)-1:0]  out_data,
  output reduce_op_t               out_op
);

  localparam int OUT_W = IN_W >> LVLS;

  logic [IN_W-1:0]  tree;
  logic [OUT_W-1:0] nxt_data;

  // Fold in place: node i of the next level only reads nodes 2i and 2i+1,
  // both at or above i, so walking i upward never clobbers an unread node.
  always_comb begin
    tree = in_data;
    for (int k = 0; k < LVLS; k++) begin
      for (int i = 0; i < (IN_W >> (k + 1)); i++) begin
        tree[i] = combine(tree[2*i], tree[2*i+1], in_op);
      end
    end
    nxt_data = tree[OUT_W-1:0];
    if (LAST && (in_op == OP_NOR)) nxt_data = ~nxt_data;
  end

  // Stage moves when it is empty or the consumer takes its item.
  assign adv = !out_vld || nxt_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_op   <= OP_OR;
    end else if (adv) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_data <= nxt_data;
        out_op   <= in_op;
      end
    end
  end

`ifdef REDUCE_TREE_PARITY_EN
  logic [IN_W-1:0]  ptree;
  logic [OUT_W-1:0] nxt_par;

  always_comb begin
    ptree = in_par;
    for (int k = 0; k < LVLS; k++) begin
      for (int i = 0; i < (IN_W >> (k + 1)); i++) begin
        ptree[i] = ptree[2*i] ^ ptree[2*i+1];
      end
    end
    nxt_par = ptree[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               out_par <= '0;
    else if (adv && in_vld)   out_par <= nxt_par;
  end
`endif

endmodule

// File: rtl/reduce_tree_pipe.sv
// ----------------------------------------------------------------------------
// reduce_tree_pipe
//   Pipelined binary reduction tree (OR / AND / XOR / NOR zero-flag) with a
//   valid/ready handshake on both sides. A register sits after every
//   LVLS_PER_STG tree levels and always after the root, so the depth is
//   N = ceil(log2(WIDTH)/LVLS_PER_STG) cycles.
//
// Parameters
//   WIDTH        : operand width, power of 2, 2..256
//   LVLS_PER_STG : tree levels per pipeline stage, 1..8
//
// Ports
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : input handshake; in_ready depends only on
//                         out_ready and stage valid bits
//   din, op             : operand and reduction mode
//   out_valid, out_ready: output handshake
//   dout                : reduction result
//   dout_par            : parity of din (only with REDUCE_TREE_PARITY_EN)
//
// Config macro: REDUCE_TREE_PARITY_EN adds a parallel XOR tree staged
// identically to the data tree, independent of op.
// ----------------------------------------------------------------------------
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int LVLS_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  reduce_op_t       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dout
`ifdef REDUCE_TREE_PARITY_EN
  ,output logic            dout_par
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int STAGES = num_stages(WIDTH, LVLS_PER_STG);

  // vld_pipe[s] is the valid bit feeding stage s; adv_pipe[s] is stage s
  // advancing. Index STAGES is the output port side.
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] adv_pipe;

  assign vld_pipe[0]      = in_valid;
  assign adv_pipe[STAGES] = out_ready;
  assign in_ready         = adv_pipe[0];
  assign out_valid        = vld_pipe[STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int FIRST_LVL = s * LVLS_PER_STG;
    // The last stage may be narrower when LEVELS is not a multiple.
    localparam int LV = ((LEVELS - FIRST_LVL) < LVLS_PER_STG) ?
                        (LEVELS - FIRST_LVL) : LVLS_PER_STG;
    localparam int IW = WIDTH >> FIRST_LVL;
    localparam int OW = IW >> LV;

    logic [IW-1:0] d_in;
    logic [OW-1:0] d_out;
    reduce_op_t    op_in;
    reduce_op_t    op_out;
`ifdef REDUCE_TREE_PARITY_EN
    logic [IW-1:0] p_in;
    logic [OW-1:0] p_out;
`endif

    if (s == 0) begin : g_head
      assign d_in  = din;
      assign op_in = op;
`ifdef REDUCE_TREE_PARITY_EN
      assign p_in  = din;
`endif
    end else begin : g_link
      assign d_in  = g_stg[s-1].d_out;
      assign op_in = g_stg[s-1].op_out;
`ifdef REDUCE_TREE_PARITY_EN
      assign p_in  = g_stg[s-1].p_out;
`endif
    end

    reduce_stage #(
      .IN_W (IW),
      .LVLS (LV),
      .LAST (s == STAGES - 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (vld_pipe[s]),
      .in_data  (d_in),
      .in_op    (op_in),
`ifdef REDUCE_TREE_PARITY_EN
      .in_par   (p_in),
      .out_par  (p_out),
`endif
      .nxt_adv  (adv_pipe[s+1]),
      .adv      (adv_pipe[s]),
      .out_vld  (vld_pipe[s+1]),
      .out_data (d_out),
      .out_op   (op_out)
    );

    if (s == STAGES - 1) begin : g_tail
      // Root op is only needed inside the stage for the NOR inversion.
      logic unused_op;
      assign unused_op = ^op_out;
      assign dout      = d_out[0];
`ifdef REDUCE_TREE_PARITY_EN
      assign dout_par  = p_out[0];
`endif
    end
  end

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Bench for reduce_tree_pipe: a 64-bit/2-level instance (N=3) for directed
// cases and a 32-bit/3-level instance (N=2) for the random sweep. Expected
// results come from a scoreboard queue fed by a plain-arithmetic model.
module tb_reduce_tree_pipe;
  import reduce_pkg::*;

  typedef struct packed { logic d; logic p; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, dout64;
  logic [63:0] din64;
  reduce_op_t  op64;
  logic        in_valid32, in_ready32, out_valid32, out_ready32, dout32;
  logic [31:0] din32;
  reduce_op_t  op32;
`ifdef REDUCE_TREE_PARITY_EN
  logic        dout_par64, dout_par32;
`endif

  reduce_tree_pipe #(.WIDTH(64), .LVLS_PER_STG(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .din(din64), .op(op64), .out_valid(out_valid64), .out_ready(out_ready64),
    .dout(dout64)
`ifdef REDUCE_TREE_PARITY_EN
    , .dout_par(dout_par64)
`endif
  );

  reduce_tree_pipe #(.WIDTH(32), .LVLS_PER_STG(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .din(din32), .op(op32), .out_valid(out_valid32), .out_ready(out_ready32),
    .dout(dout32)
`ifdef REDUCE_TREE_PARITY_EN
    , .dout_par(dout_par32)
`endif
  );

  int errors = 0, checks = 0, cyc = 0;
  int n_out64 = 0, n_out32 = 0;
  exp_t q64[$], q32[$];
  logic s_ov64, s_d64, s_ir64, s_acc64, s_ov32, s_d32, s_ir32, s_acc32;
  logic s_p64, s_p32;
  logic hold64 = 1'b0, hold_d64, hold_p64, hold32 = 1'b0, hold_d32, hold_p32;

  reduce_op_t mode_ops [4] = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
  logic       mode_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] bp_din [8];
  reduce_op_t  bp_op  [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: reduction over the low w bits, straight from the op meaning.
  function automatic logic ref_red(input logic [63:0] v, input int w, input reduce_op_t o);
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    v = v & m;
    case (o)
      OP_OR:   return v != 64'd0;
      OP_AND:  return v == m;
      OP_XOR:  return ($countones(v) % 2) == 1;
      default: return v == 64'd0;
    endcase
  endfunction

  function automatic logic ref_par(input logic [63:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  // One clock: sample at the falling edge, score both DUTs, then step to
  // just after the next rising edge where the caller drives new inputs.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_ov64 = out_valid64; s_d64 = dout64; s_ir64 = in_ready64; s_acc64 = in_valid64 && in_ready64;
    s_ov32 = out_valid32; s_d32 = dout32; s_ir32 = in_ready32; s_acc32 = in_valid32 && in_ready32;
`ifdef REDUCE_TREE_PARITY_EN
    s_p64 = dout_par64; s_p32 = dout_par32;
`else
    s_p64 = 1'b0; s_p32 = 1'b0;
`endif
    if (hold64) begin
      chk("hold_valid64", out_valid64, 1'b1);
      chk("hold_dout64", dout64, hold_d64);
`ifdef REDUCE_TREE_PARITY_EN
      chk("hold_par64", dout_par64, hold_p64);
`endif
    end
    if (out_valid64 && out_ready64) begin
      if (q64.size() == 0) chk("spurious64", out_valid64, 1'b0);
      else begin
        e = q64.pop_front();
        chk("dout64", dout64, e.d);
`ifdef REDUCE_TREE_PARITY_EN
        chk("par64", dout_par64, e.p);
`endif
        n_out64++;
      end
    end
    if (s_acc64) q64.push_back('{d: ref_red(din64, 64, op64), p: ref_par(din64)});
    hold64 = out_valid64 && !out_ready64; hold_d64 = dout64; hold_p64 = s_p64;

    if (hold32) begin
      chk("hold_valid32", out_valid32, 1'b1);
      chk("hold_dout32", dout32, hold_d32);
`ifdef REDUCE_TREE_PARITY_EN
      chk("hold_par32", dout_par32, hold_p32);
`endif
    end
    if (out_valid32 && out_ready32) begin
      if (q32.size() == 0) chk("spurious32", out_valid32, 1'b0);
      else begin
        e = q32.pop_front();
        chk("dout32", dout32, e.d);
`ifdef REDUCE_TREE_PARITY_EN
        chk("par32", dout_par32, e.p);
`endif
        n_out32++;
      end
    end
    if (s_acc32) q32.push_back('{d: ref_red({32'd0, din32}, 32, op32), p: ref_par({32'd0, din32})});
    hold32 = out_valid32 && !out_ready32; hold_d32 = dout32; hold_p32 = s_p32;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic v, input logic [63:0] d, input reduce_op_t o);
    in_valid64 = v; din64 = d; op64 = o;
  endtask

  initial begin
    int idx, base, acc;
    logic saw_stall;
    rst_n = 1'b0;
    in_valid64 = 1'b0; din64 = '0; op64 = OP_OR; out_ready64 = 1'b1;
    in_valid32 = 1'b0; din32 = '0; op32 = OP_OR; out_ready32 = 1'b1;
    #1;

    // Reset state
    tick();
    chk("rst_ov64", s_ov64, 1'b0); chk("rst_dout64", s_d64, 1'b0); chk("rst_par64", s_p64, 1'b0);
    chk("rst_ov32", s_ov32, 1'b0); chk("rst_dout32", s_d32, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready64", s_ir64, 1'b1);
    chk("post_rst_ready32", s_ir32, 1'b1);

    // Zero flag: din=0 then MSB set, NOR
    drive64(1'b1, 64'd0, OP_NOR); tick();
    drive64(1'b1, 64'h8000_0000_0000_0000, OP_NOR); tick();
    drive64(1'b0, 64'd0, OP_OR); tick();
    chk("zf_c2_valid", s_ov64, 1'b0);
    tick(); chk("zf_c3_valid", s_ov64, 1'b1); chk("zf_c3_dout", s_d64, 1'b1);
    tick(); chk("zf_c4_valid", s_ov64, 1'b1); chk("zf_c4_dout", s_d64, 1'b0);
    tick(); chk("zf_c5_valid", s_ov64, 1'b0);

    // All modes back-to-back on all-ones
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive64(1'b1, {64{1'b1}}, mode_ops[i]);
      else       drive64(1'b0, 64'd0, OP_OR);
      tick();
      if (i >= 3 && i <= 6) begin
        chk("mode_valid", s_ov64, 1'b1);
        chk("mode_dout", s_d64, mode_exp[i-3]);
      end else begin
        chk("mode_idle_valid", s_ov64, 1'b0);
      end
    end

    // Backpressure: 8 operands, out_ready low for cycles 4..7
    for (int i = 0; i < 8; i++) begin
      bp_din[i] = {$urandom, $urandom};
      if (i % 3 == 0) bp_din[i] = 64'd0;
      bp_op[i]  = reduce_op_t'($urandom_range(0, 3));
    end
    base = n_out64; idx = 0; saw_stall = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (idx < 8) drive64(1'b1, bp_din[idx], bp_op[idx]);
      else         drive64(1'b0, 64'd0, OP_OR);
      out_ready64 = !(k >= 4 && k <= 7);
      tick();
      if (k == 4) chk("bp_ready_full", s_ir64, 1'b0);
      if (!s_ir64) saw_stall = 1'b1;
      if (s_acc64) idx++;
    end
    chk("bp_sent", idx, 8);
    chk("bp_recv", n_out64 - base, 8);
    chk("bp_saw_stall", saw_stall, 1'b1);
    chk("bp_queue_empty", q64.size(), 0);

    // Reset with two operands in flight and the output stalled
    out_ready64 = 1'b0;
    drive64(1'b1, 64'd5, OP_OR); tick();
    drive64(1'b1, 64'd0, OP_NOR); tick();
    drive64(1'b0, 64'd0, OP_OR); tick();
    tick();
    chk("mf_valid_before", s_ov64, 1'b1);
    rst_n = 1'b0;
    q64.delete(); q32.delete(); hold64 = 1'b0; hold32 = 1'b0;
    tick();
    chk("mf_valid_in_rst", s_ov64, 1'b0);
    chk("mf_dout_in_rst", s_d64, 1'b0);
    rst_n = 1'b1; out_ready64 = 1'b1;
    tick();
    chk("mf_ready_after", s_ir64, 1'b1);
    base = n_out64;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mf_no_result", s_ov64, 1'b0);
    end

`ifdef REDUCE_TREE_PARITY_EN
    // Parity tree independent of op
    drive64(1'b1, 64'h7, OP_OR); tick();
    drive64(1'b1, 64'h3, OP_OR); tick();
    drive64(1'b0, 64'd0, OP_OR); tick();
    tick(); chk("par7_dout", s_d64, 1'b1); chk("par7_par", s_p64, 1'b1);
    tick(); chk("par3_dout", s_d64, 1'b1); chk("par3_par", s_p64, 1'b0);
    tick();
`endif

    // Sweep on the 32-bit / 3-level instance: full-rate window first
    base = n_out32; acc = 0;
    for (int i = 0; i < 200; i++) begin
      in_valid32 = 1'b1; din32 = $urandom; op32 = reduce_op_t'($urandom_range(0, 3));
      if (i % 17 == 0) din32 = 32'd0;
      if (i % 19 == 0) din32 = 32'hFFFF_FFFF;
      tick();
      if (s_acc32) acc++;
      if (i == 1) chk("sw_lat_c1", s_ov32, 1'b0);
      if (i == 2) chk("sw_lat_c2", s_ov32, 1'b1);
    end
    chk("sw_full_acc", acc, 200);
    chk("sw_full_rate", n_out32 - base, 198);

    // Random valid/ready on both instances: bubbles and stalls together
    for (int k = 0; k < 6000 && acc < 1000; k++) begin
      in_valid32  = ($urandom_range(0, 3) != 0);
      out_ready32 = ($urandom_range(0, 3) != 0);
      din32 = $urandom; op32 = reduce_op_t'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) din32 = 32'd0;
      if ($urandom_range(0, 9) == 0) din32 = 32'hFFFF_FFFF;
      in_valid64  = ($urandom_range(0, 1) != 0);
      out_ready64 = ($urandom_range(0, 2) != 0);
      din64 = {$urandom, $urandom}; op64 = reduce_op_t'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) din64 = 64'd0;
      tick();
      if (s_acc32) acc++;
    end
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    in_valid64 = 1'b0; out_ready64 = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("sw_accepted", acc, 1000);
    chk("sw_received", n_out32 - base, 1000);
    chk("sw_queue32_empty", q32.size(), 0);
    chk("rnd_queue64_empty", q64.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reduce_tree_pipe.md
REDUCE_TREE_PIPE -- requirements
Module: reduce_tree_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, input bit count; power of 2, range 2..256.
REQ-002 SHALL have parameter LVLS_PER_STG, default 2, number of 2-input tree levels between pipeline registers; range 1..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the operand and op are valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts in_valid this cycle.
REQ-007 SHALL have port din, input, WIDTH, the operand to reduce.
REQ-008 SHALL have port op, input, 2, reduction mode of type reduce_op_t.
REQ-009 SHALL have port out_valid, output, 1, dout is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts dout.
REQ-011 SHALL have port dout, output, 1, the reduction result.
REQ-012 SHALL have port dout_par, output, 1, the parity of din; present only with REDUCE_TREE_PARITY_EN.

Function
REQ-013 SHALL provide op encoding OP_OR=0, OP_AND=1, OP_XOR=2, OP_NOR=3; OP_NOR is the zero flag: 1 iff din==0.
REQ-014 SHALL build a binary tree of log2(WIDTH) levels, with level k combining node pairs 2i and 2i+1.
REQ-015 SHALL register every LVLS_PER_STG levels, and register the final level unconditionally; pipeline depth N = ceil(log2(WIDTH)/LVLS_PER_STG).
REQ-016 SHALL carry op and a valid bit alongside the data through each stage.
REQ-017 SHALL apply the NOR inversion only at the final stage; stages internal to the tree SHALL use OR for OP_NOR.
REQ-018 SHALL have latency N cycles from an accepted input (in_valid && in_ready) to out_valid with no backpressure; with WIDTH=64 and LVLS_PER_STG=2, N=3.
REQ-019 SHALL sustain one result per cycle while out_ready=1.
REQ-020 SHALL advance stage s when stage s is empty or stage s+1 advances; the last stage SHALL advance when it is empty or out_ready=1.
REQ-021 SHALL drive in_ready = first-stage advance condition, combinational from out_ready through the stage valid bits, with no combinational path from in_valid.
REQ-022 SHALL hold dout, dout_par and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL leave the pipeline unchanged when in_valid=1 and in_ready=0.
REQ-024 SHALL lose no data and duplicate no data when a bubble and a stall occur in the same cycle.
REQ-025 SHALL insert a bubble (valid=0) into stage 1 when in_valid=0 and stage 1 advances.

Reset
REQ-026 SHALL clear all stage valid bits immediately on rst_n=0, independent of clk.
REQ-027 SHALL hold out_valid=0, dout=0 and dout_par=0 during reset; stage data registers SHALL also be cleared.
REQ-028 SHALL drive in_ready=1 from the first cycle after rst_n deasserts.
REQ-029 SHALL discard all in-flight results when reset asserts mid-operation; none SHALL appear after release.

Configuration
REQ-030 SHALL use macro REDUCE_TREE_PARITY_EN: when defined, a parallel XOR tree SHALL be staged identically and drive dout_par, whatever the value of op.
REQ-031 SHALL omit the dout_par port and parity registers when REDUCE_TREE_PARITY_EN is undefined; all other behaviour SHALL be identical.

Structure
REQ-032 SHALL place reduce_op_t, the OP_* constants and a function clog2-based stage count in package reduce_pkg.
REQ-033 SHALL use sub-module reduce_stage for one pipeline stage: LVLS_PER_STG combinational levels, op-dependent combine, and the valid/data register with stall.
REQ-034 SHALL instantiate reduce_stage N times in a generate loop, with a narrower final stage when log2(WIDTH) is not a multiple of LVLS_PER_STG.

Verification
REQ-035 SHALL cover zero flag: WIDTH=64, op=NOR, din=0 then din=64'h8000_0000_0000_0000, out_ready=1 -> dout=1 at cycle 3, dout=0 at cycle 4.
REQ-036 SHALL cover modes: din=64'hFFFF_FFFF_FFFF_FFFF with AND/OR/XOR/NOR back-to-back -> dout 1,1,0,0 on consecutive cycles starting at latency 3.
REQ-037 SHALL cover backpressure: stream 8 operands, out_ready=0 for cycles 4-7 -> in_ready=0 once 3 stages are full, all 8 results in order, none lost or duplicated.
REQ-038 SHALL cover reset mid-flight: 2 operands in flight, rst_n=0 for 1 cycle -> out_valid=0 immediately, no result after release.
REQ-039 SHALL cover parity: with REDUCE_TREE_PARITY_EN, din=64'h0000_0000_0000_0007, op=OR -> dout=1, dout_par=1; din=64'h3 -> dout_par=0.
REQ-040 SHALL cover parameter sweep: WIDTH=32, LVLS_PER_STG=3 -> N=2; 1000 random operands against a reference model, one result per cycle.
